// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank.
// Frame layout: R/W bit, address, data, MSB first.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic CMD_WRITE = 1'b1;

  function automatic int frame_len(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync.sv
// Two-flop synchroniser for asynchronous SPI pins.
// The reset value is chosen per pin by the instantiating block.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave with a write/read-back register bank.
// All pins are synchronised; everything runs on clk.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                NUM_REGS  = 5,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       sdi,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       frame_err_o
);

  localparam int FLEN  = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FLEN + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FLEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FLEN + 1);
  localparam logic [CNT_W-1:0]  CNT_RD   = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

  logic [2:0] pins_s;
  logic       sclk_s;
  logic       cs_s;
  logic       sdi_s;
  logic       sclk_d;
  logic       cs_d;

  // cs_n resets to 0 so a select already low at release is not a start
  sync_2ff #(
    .WIDTH  (3),
    .RST_VAL(3'b000)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({sclk, cs_n, sdi}),
    .q    (pins_s)
  );

  assign sclk_s = pins_s[2];
  assign cs_s   = pins_s[1];
  assign sdi_s  = pins_s[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  state_t state_q;
  state_t state_d;
  logic   start;
  logic   shift_en;
  logic   fall_en;
  logic   commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    fall_en  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end else begin
          shift_en = sclk_rise;
          fall_en  = sclk_fall;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [FLEN-1:0]   rx_q;
  logic [FLEN-1:0]   rx_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tx_q;
  logic              sdo_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              load;

  assign rx_nxt  = {rx_q[FLEN-2:0], sdi_s};
  assign rd_addr = rx_nxt[ADDR_W-1:0];
  assign load    = shift_en && (cnt_q == CNT_RD)
                && (rx_nxt[ADDR_W] != CMD_WRITE);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_data = regs_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q  <= '0;
      cnt_q <= '0;
      tx_q  <= '0;
      sdo_q <= 1'b0;
    end else if (start) begin
      rx_q  <= '0;
      cnt_q <= '0;
      tx_q  <= '0;
      sdo_q <= 1'b0;
    end else begin
      if (shift_en) begin
        rx_q <= rx_nxt;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        if (load) tx_q <= rd_data;
      end
      if (fall_en) begin
        sdo_q <= tx_q[DATA_W-1];
        tx_q  <= tx_q << 1;
      end
      if (state_q != SHIFT) sdo_q <= 1'b0;
    end
  end

  logic              rw_f;
  logic [ADDR_W-1:0] addr_f;
  logic [DATA_W-1:0] data_f;
  logic              valid;

  assign rw_f   = rx_q[FLEN-1];
  assign addr_f = rx_q[DATA_W +: ADDR_W];
  assign data_f = rx_q[DATA_W-1:0];
  assign valid  = (cnt_q == CNT_FULL) && ({1'b0, addr_f} < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
      wr_pulse_o  <= 1'b0;
      wr_addr_o   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      wr_pulse_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (commit) begin
        if (!valid) begin
          frame_err_o <= 1'b1;
        end else if (rw_f == CMD_WRITE) begin
          wr_pulse_o <= 1'b1;
          wr_addr_o  <= addr_f;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_f == ADDR_W'(k)) regs_q[k] <= data_f;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign sdo = sdo_q & ~cs_n;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default bank plus a
// 16x16 instance sharing sclk/sdi with its own select.
module tb_spi_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         cs_n2 = 1'b1;
  logic         sdi = 1'b0;
  logic         sdo;
  logic         sdo2;
  logic [39:0]  regs_o;
  logic [255:0] regs2;
  logic         wr_pulse;
  logic         wr_pulse2;
  logic [6:0]   wr_addr;
  logic [6:0]   wr_addr2;
  logic         frame_err;
  logic         frame_err2;

  int checks = 0;
  int passes = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int wr_cnt2 = 0;
  int err_cnt2 = 0;
  bit sel2 = 1'b0;

  always #5 clk = ~clk;

  spi_reg_bank u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .sdi        (sdi),
    .sdo        (sdo),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse),
    .wr_addr_o  (wr_addr),
    .frame_err_o(frame_err)
  );

  spi_reg_bank #(
    .NUM_REGS(16),
    .ADDR_W  (7),
    .DATA_W  (16)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n2),
    .sdi        (sdi),
    .sdo        (sdo2),
    .regs_o     (regs2),
    .wr_pulse_o (wr_pulse2),
    .wr_addr_o  (wr_addr2),
    .frame_err_o(frame_err2)
  );

  always @(posedge clk) begin
    if (wr_pulse)   wr_cnt++;
    if (frame_err)  err_cnt++;
    if (wr_pulse2)  wr_cnt2++;
    if (frame_err2) err_cnt2++;
  end

  task automatic cs_low();
    if (sel2) cs_n2 = 1'b0;
    else      cs_n  = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    if (sel2) cs_n2 = 1'b1;
    else      cs_n  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // sdo sampled just before each rising sclk, as a mode-0 host would
  task automatic shift_bits(
    input  int          n,
    input  logic [31:0] v,
    output logic [31:0] miso
  );
    miso = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      repeat (4) @(negedge clk);
      miso = {miso[30:0], sel2 ? sdo2 : sdo};
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(
    input  int          n,
    input  logic [31:0] v,
    output logic [31:0] miso
  );
    cs_low();
    shift_bits(n, v, miso);
    cs_high();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (regs_o !== 40'h0) $display("FAIL reset_regs got %h want 0", regs_o);
    else passes++;
    checks++;
    if ({sdo, wr_pulse, frame_err, wr_addr} !== 10'h0)
      $display("FAIL reset_outs got %b%b%b %h want 0", sdo, wr_pulse, frame_err, wr_addr);
    else passes++;
    checks++;
    if (regs2 !== 256'h0) $display("FAIL reset_regs2 got %h want 0", regs2);
    else passes++;
  endtask

  task automatic test_bad_addr();
    logic [31:0] m;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame(16, 32'h85A5, m);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1) $display("FAIL bad_addr_err got %0d want 1", err_cnt - e0);
    else passes++;
    checks++;
    if (wr_cnt - w0 !== 0 || regs_o !== 40'h0)
      $display("FAIL bad_addr_nowrite got %0d %h want 0 0", wr_cnt - w0, regs_o);
    else passes++;
  endtask

  task automatic test_write();
    logic [31:0] m;
    int w0;
    w0 = wr_cnt;
    cs_low();
    shift_bits(16, 32'h823C, m);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_pulse !== 1'b0 || regs_o !== 40'h0)
      $display("FAIL write_early got %b %h want 0 0", wr_pulse, regs_o);
    else passes++;
    @(negedge clk);
    checks++;
    if (wr_pulse !== 1'b1 || regs_o !== 40'h00003C0000 || wr_addr !== 7'd2)
      $display("FAIL write_commit got %b %h %h want 1 00003c0000 02", wr_pulse, regs_o, wr_addr);
    else passes++;
    @(negedge clk);
    checks++;
    if (wr_pulse !== 1'b0) $display("FAIL write_pulse_len got %b want 0", wr_pulse);
    else passes++;
    repeat (8) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1) $display("FAIL write_count got %0d want 1", wr_cnt - w0);
    else passes++;
  endtask

  task automatic test_read();
    logic [31:0] m;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame(16, 32'h0200, m);
    checks++;
    if (m[15:0] !== 16'h003C) $display("FAIL read_sdo got %h want 003c", m[15:0]);
    else passes++;
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0 || regs_o !== 40'h00003C0000)
      $display("FAIL read_side got %0d %0d %h want 0 0 00003c0000", wr_cnt - w0, err_cnt - e0, regs_o);
    else passes++;
    checks++;
    if (sdo !== 1'b0) $display("FAIL read_sdo_idle got %b want 0", sdo);
    else passes++;
  endtask

  task automatic test_bad_length();
    logic [31:0] m;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame(12, 32'h815, m);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0 || regs_o !== 40'h00003C0000)
      $display("FAIL short_frame got %0d %0d %h want 1 0 00003c0000", err_cnt - e0, wr_cnt - w0, regs_o);
    else passes++;
    w0 = wr_cnt; e0 = err_cnt;
    frame(17, 32'h102AB, m);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0 || regs_o !== 40'h00003C0000)
      $display("FAIL long_frame got %0d %0d %h want 1 0 00003c0000", err_cnt - e0, wr_cnt - w0, regs_o);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] m;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    shift_bits(9, 32'h106, m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    shift_bits(7, 32'h77, m);
    cs_high();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0 || regs_o !== 40'h0)
      $display("FAIL midreset_discard got %0d %0d %h want 0 0 0", wr_cnt - w0, err_cnt - e0, regs_o);
    else passes++;
    w0 = wr_cnt;
    frame(16, 32'h8377, m);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1 || regs_o !== 40'h0077000000 || wr_addr !== 7'd3)
      $display("FAIL midreset_next got %0d %h %h want 1 0077000000 03", wr_cnt - w0, regs_o, wr_addr);
    else passes++;
  endtask

  task automatic test_wide_bank();
    logic [31:0]  m;
    logic [15:0]  d;
    logic [255:0] exp;
    int w0, e0;
    sel2 = 1'b1;
    w0 = wr_cnt2; e0 = err_cnt2;
    exp = '0;
    for (int a = 0; a < 16; a++) begin
      d = 16'(a * 16'h1111);
      exp[a*16 +: 16] = d;
      frame(24, {8'h0, 1'b1, 7'(a), d}, m);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (regs2 !== exp) $display("FAIL wide_regs got %h want %h", regs2, exp);
    else passes++;
    checks++;
    if (wr_cnt2 - w0 !== 16 || err_cnt2 - e0 !== 0 || wr_addr2 !== 7'd15)
      $display("FAIL wide_pulses got %0d %0d %h want 16 0 0f", wr_cnt2 - w0, err_cnt2 - e0, wr_addr2);
    else passes++;
    for (int a = 0; a < 16; a++) begin
      d = 16'(a * 16'h1111);
      frame(24, {8'h0, 1'b0, 7'(a), 16'h0}, m);
      checks++;
      if (m[23:0] !== {8'h0, d})
        $display("FAIL wide_read_%0d got %h want %h", a, m[23:0], {8'h0, d});
      else passes++;
    end
    checks++;
    if (regs_o !== 40'h0077000000) $display("FAIL wide_isolation got %h want 0077000000", regs_o);
    else passes++;
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bad_addr();
    test_write();
    test_read();
    test_bad_length();
    test_reset_mid_frame();
    test_wide_bank();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
